// File: rtl/dft_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dft_seq_pkg
//  Description : Shared types and defaults for the DFT frame sequencer and
//                the CSR status readback.
//  Revision    : 1.0 - initial release
// ============================================================================
package dft_seq_pkg;

    localparam int STATE_W             = 3;
    localparam int DEF_MAX_LOG2_POINTS = 13;
    localparam int DEF_MIN_LOG2_POINTS = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_RUN       = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_READOUT   = 3'd4
    } seq_state_e;

    // True when a requested frame size (log2) lies inside the supported range
    function automatic logic cfg_in_range(input logic [3:0] k, input int lo, input int hi);
        return (int'(k) >= lo) && (int'(k) <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_edge_detect
//  Description : Rising-edge detector. Both the previous value and the output
//                pulse are registered, so the pulse follows the input edge by
//                one cycle and no combinational path crosses this block.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse_out
);

    logic r_prev;
    logic r_pulse;

    // Remember last input level and flag a 0->1 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= sig_in;
            r_pulse <= sig_in & ~r_prev;
        end
    end

    assign pulse_out = r_pulse;

endmodule
`default_nettype wire

// File: rtl/dft_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dft_sequencer
//  Description : Frame-level controller for the radix-2 FFT core. Admits one
//                2^k-sample frame, starts the transform, waits for done,
//                triggers DMA readout and re-arms. Sticky error reporting for
//                dropped samples, framing faults, bad config and core hangs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dft_sequencer
    import dft_seq_pkg::*;
#(
    parameter int MAX_LOG2_POINTS = DEF_MAX_LOG2_POINTS,
    parameter int MIN_LOG2_POINTS = DEF_MIN_LOG2_POINTS,
    parameter int FRAME_CNT_W     = 16,
    parameter int DONE_TIMEOUT    = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_enable,
    input  logic [3:0]             cfg_log2_points,
    input  logic                   err_clear,
    input  logic                   sink_valid,
    input  logic                   sink_sop,
    input  logic                   sink_eop,
    output logic                   sink_ready,
    output logic                   core_sact,
    output logic                   core_run,
    output logic                   core_fin,
    input  logic                   core_done,
    output logic                   reader_trigger,
    input  logic                   reader_busy,
    output logic [STATE_W-1:0]     seq_state,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   drop_err,
    output logic                   framing_err,
    output logic                   cfg_err,
    output logic                   timeout_err
);

    localparam int c_CNT_W = MAX_LOG2_POINTS;
    localparam int c_TMR_W = $clog2(DONE_TIMEOUT + 1);

    seq_state_e               r_state, w_next_state;
    logic [c_CNT_W-1:0]       r_count, w_count_next;
    logic [c_CNT_W-1:0]       r_last, w_last_next;
    logic [c_TMR_W-1:0]       r_timer, w_timer_next;
    logic                     r_ro_seen, w_ro_seen_next;
    logic                     r_sink_ready, r_core_run, r_core_fin, r_reader_trigger;
    logic [FRAME_CNT_W-1:0]   r_frame_count;
    logic                     r_drop_err, r_framing_err, r_cfg_err, r_timeout_err;
    logic                     w_fin, w_frame_done;
    logic                     w_drop_set, w_framing_set, w_cfg_set, w_timeout_set;
    logic                     w_done_rise, w_abort, w_sact;
    logic [c_CNT_W-1:0]       w_idx;

    pulse_edge_detect u_done_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (core_done),
        .pulse_out (w_done_rise)
    );

    // A sample is handed to the core unless it would start a frame without sop
    assign w_sact     = sink_valid & r_sink_ready & ((r_count != '0) | sink_sop);
    // sop always (re)starts the frame at index 0
    assign w_idx      = sink_sop ? '0 : r_count;
    assign w_drop_set = sink_valid & ~r_sink_ready & (r_state != S_IDLE);
    assign w_abort    = ~cfg_enable &
                        ((r_state == S_FILL) | (r_state == S_RUN) | (r_state == S_WAIT_DONE));

    // Next-state, counter and error-event decode
    always_comb begin
        w_next_state   = r_state;
        w_count_next   = r_count;
        w_last_next    = r_last;
        w_timer_next   = r_timer;
        w_ro_seen_next = r_ro_seen;
        w_fin          = 1'b0;
        w_frame_done   = 1'b0;
        w_cfg_set      = 1'b0;
        w_framing_set  = 1'b0;
        w_timeout_set  = 1'b0;
        if (w_abort) begin
            w_next_state = S_IDLE;
            w_fin        = 1'b1;
            w_count_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_enable) begin
                        if (cfg_in_range(cfg_log2_points, MIN_LOG2_POINTS, MAX_LOG2_POINTS)) begin
                            w_last_next  = c_CNT_W'((32'd1 << cfg_log2_points) - 32'd1);
                            w_count_next = '0;
                            w_next_state = S_FILL;
                        end else begin
                            w_cfg_set = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (sink_valid) begin
                        if (!w_sact) begin
                            w_framing_set = 1'b1;
                        end else begin
                            if ((sink_sop && (r_count != '0)) || (sink_eop && (w_idx != r_last))) begin
                                w_framing_set = 1'b1;
                            end
                            if (w_idx == r_last) begin
                                w_next_state = S_RUN;
                                w_count_next = '0;
                            end else begin
                                w_count_next = w_idx + 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    w_next_state = S_WAIT_DONE;
                    w_timer_next = '0;
                end
                S_WAIT_DONE: begin
                    if (w_done_rise) begin
                        w_next_state   = S_READOUT;
                        w_ro_seen_next = 1'b0;
                    end else if (r_timer == c_TMR_W'(DONE_TIMEOUT - 1)) begin
                        // Action lands on the DONE_TIMEOUT-th cycle after entry
                        w_timeout_set = 1'b1;
                        w_fin         = 1'b1;
                        w_count_next  = '0;
                        w_next_state  = S_FILL;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                S_READOUT: begin
                    // First cycle never exits, giving a two-cycle minimum
                    if (r_ro_seen && !reader_busy) begin
                        w_frame_done = 1'b1;
                        w_count_next = '0;
                        w_next_state = cfg_enable ? S_FILL : S_IDLE;
                    end else begin
                        w_ro_seen_next = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // State, counters, registered strobes and sticky errors (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_count          <= '0;
            r_last           <= '0;
            r_timer          <= '0;
            r_ro_seen        <= 1'b0;
            r_sink_ready     <= 1'b0;
            r_core_run       <= 1'b0;
            r_core_fin       <= 1'b0;
            r_reader_trigger <= 1'b0;
            r_frame_count    <= '0;
            r_drop_err       <= 1'b0;
            r_framing_err    <= 1'b0;
            r_cfg_err        <= 1'b0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_count          <= w_count_next;
            r_last           <= w_last_next;
            r_timer          <= w_timer_next;
            r_ro_seen        <= w_ro_seen_next;
            r_sink_ready     <= (w_next_state == S_FILL);
            r_core_run       <= (w_next_state == S_RUN);
            r_core_fin       <= w_fin;
            r_reader_trigger <= (w_next_state == S_READOUT) && (r_state != S_READOUT);
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            r_drop_err       <= w_drop_set    | (r_drop_err    & ~err_clear);
            r_framing_err    <= w_framing_set | (r_framing_err & ~err_clear);
            r_cfg_err        <= w_cfg_set     | (r_cfg_err     & ~err_clear);
            r_timeout_err    <= w_timeout_set | (r_timeout_err & ~err_clear);
        end
    end

    assign sink_ready     = r_sink_ready;
    assign core_sact      = w_sact;
    assign core_run       = r_core_run;
    assign core_fin       = r_core_fin;
    assign reader_trigger = r_reader_trigger;
    assign seq_state      = r_state;
    assign frame_count    = r_frame_count;
    assign drop_err       = r_drop_err;
    assign framing_err    = r_framing_err;
    assign cfg_err        = r_cfg_err;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/dft_sequencer.md
# dft_sequencer

Frame-level controller for the radix-2 FFT datapath and its memory reader in the DSP chain. It admits exactly one 2^k-sample frame from the Avalon-ST sink into the FFT core and starts the transform. It then waits for completion, triggers DMA readout, and re-arms for the next frame. It also detects dropped samples, framing faults and core hangs, and reports them as sticky status for the CSR block.

## Interface
- MAX_LOG2_POINTS, 13: largest supported frame size, log2. Matches the 13-bit core DMA address.
- MIN_LOG2_POINTS, 4: smallest supported frame size, log2.
- FRAME_CNT_W, 16: width of the completed-frame counter.
- DONE_TIMEOUT, 65535: maximum cycles allowed in WAIT_DONE.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  level. 1 runs the frame loop; 0 aborts to IDLE.
- cfg_log2_points  in  4  frame size, log2. Sampled on the IDLE->FILL transition.
- err_clear  in  1  single-cycle pulse that clears all sticky errors.
- sink_valid / sink_sop / sink_eop  in  1 each  upstream Avalon-ST qualifiers.
- sink_ready  out  1  registered. High only in FILL.
- core_sact  out  1  sample strobe to the core: sink_valid & sink_ready & (count!=0 | sink_sop).
- core_run  out  1  registered one-cycle start pulse.
- core_fin  out  1  registered one-cycle core reset pulse.
- core_done  in  1  core done level.
- reader_trigger  out  1  registered one-cycle pulse to the memory reader.
- reader_busy  in  1  memory reader activity level.
- seq_state  out  3  current state encoding.
- frame_count  out  FRAME_CNT_W  completed frames. Wraps.
- drop_err / framing_err / cfg_err / timeout_err  out  1 each  sticky error flags.

## Operation
- All outputs reset to 0, state resets to IDLE, and the sample counter resets to 0.
- State encoding: IDLE=0, FILL=1, RUN=2, WAIT_DONE=3, READOUT=4.
- IDLE: exits only when cfg_enable=1.
  - If cfg_log2_points is within [MIN,MAX], latch N=2^k and go to FILL.
  - Otherwise set cfg_err and stay in IDLE.
- FILL: sink_ready=1.
  - With count=0, a sample without sop is discarded (core_sact=0) and sets framing_err.
  - A sop sample while count!=0 sets framing_err and restarts the count at 1; that sample is passed to the core.
  - eop on an accepted sample with count!=N-1 sets framing_err and does not end the frame.
  - The accepted sample at count=N-1 ends the frame: go to RUN and clear count.
- RUN: lasts one cycle. core_run=1 is asserted in the same cycle, then go to WAIT_DONE and zero the timeout counter.
- WAIT_DONE: watches for a core_done rising edge, using a registered previous value.
  - On an edge, go to READOUT, with reader_trigger=1 in the first READOUT cycle.
  - If the timeout counter reaches DONE_TIMEOUT first: set timeout_err, pulse core_fin, and go to FILL.
- READOUT: stays for a minimum of 2 cycles, then exits on the first cycle with reader_busy=0.
  - On exit, increment frame_count and go to FILL. If cfg_enable=0 at that point, go to IDLE instead.
- Dropped-sample detection: drop_err is set by sink_valid=1 while sink_ready=0, in any state except IDLE.
- Abort: cfg_enable=0 in FILL, RUN or WAIT_DONE goes to IDLE on the next cycle, pulses core_fin and clears count. READOUT instead finishes normally.
- err_clear and a new error event in the same cycle: the set wins.
- cfg_log2_points changing outside IDLE has no effect.

## Timing
- Frame of N samples accepted back-to-back: the last sample is at cycle t, core_run is high at t+1, and the state is WAIT_DONE at t+2.
- core_done rises at cycle d: reader_trigger is high at d+2, because of the edge register plus the state register.
- sink_ready falls in the cycle after the last accepted sample. Upstream must tolerate ready latency 0.
- core_sact is combinational from registered state/count and the live sink_valid/sop. There is no combinational path from core_done or reader_busy to any output.
- core_done already high on entry to WAIT_DONE is not an edge. The bench must see a 0->1 transition.

## Structure
- Shared package dft_seq_pkg:
  - seq_state_e enum.
  - MIN/MAX_LOG2_POINTS defaults.
  - STATE_W=3.
  - This package is imported by the CSR mapping for the status readback.
- One sub-module, pulse_edge_detect (rising-edge detector with registered previous value), used for core_done.
- Everything else lives in one always_ff state/counter process plus one always_comb output/next-state block.

## Test plan
- cfg_log2_points=4, 16 samples with sop on the first and eop on the last:
  - 16 core_sact pulses, then one core_run.
  - core_done rise -> reader_trigger two cycles later.
  - reader_busy high 20 cycles -> frame_count=1, state FILL.
- 3 samples without sop, then a valid 16-sample frame: the first 3 are dropped (core_sact=0), framing_err=1, and the frame still completes.
- sink_valid held high during WAIT_DONE: drop_err=1. After err_clear, drop_err=0 and the other flags are unchanged.
- core_done never asserted, with DONE_TIMEOUT=100:
  - timeout_err=1 and core_fin pulses exactly at WAIT_DONE cycle 100.
  - The state returns to FILL.
- cfg_log2_points=14 -> cfg_err=1 and the state stays IDLE. With cfg_log2_points=13, an 8192-sample frame completes.
- Abort and reset:
  - cfg_enable dropped mid-FILL at count 7 -> core_fin pulse, IDLE. A new enable starts from count 0.
  - rst_n asserted in READOUT clears all outputs asynchronously.
